// File: rtl/apb_initiator.sv
// APB requester: converts a valid/ready command stream into single APB transfers
// and returns one valid/ready response per command, with a bus-hang timeout.
module apb_initiator #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              apbm_psel,
    output logic              apbm_penable,
    output logic              apbm_pwrite,
    output logic [ADDR_W-1:0] apbm_paddr,
    output logic [31:0]       apbm_pwdata,
    input  logic [31:0]       apbm_prdata,
    input  logic              apbm_pready,
    input  logic              apbm_pslverr
);

    // Counter wide enough to reach TIMEOUT; it saturates so a disabled timeout never wraps.
    localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t              state_reg, state_next;
    logic                psel_reg, psel_next;
    logic                penable_reg, penable_next;
    logic                pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0]   paddr_reg, paddr_next;
    logic [31:0]         pwdata_reg, pwdata_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [31:0]         rsp_rdata_reg, rsp_rdata_next;
    logic                rsp_err_reg, rsp_err_next;
    logic                rsp_timeout_reg, rsp_timeout_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0]    cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
            cnt_reg         <= cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        cnt_next         = cnt_reg;
        cnt_inc          = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

        case (state_reg)
            IDLE: begin
                // cmd_ready is implied here: we only evaluate IDLE outside reset.
                if (cmd_valid) begin
                    pwrite_next  = cmd_write;
                    paddr_next   = cmd_addr;
                    pwdata_next  = cmd_wdata;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (apbm_pready) begin
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = pwrite_reg ? 32'h0 : apbm_prdata;
                    rsp_err_next     = apbm_pslverr;
                    rsp_timeout_next = 1'b0;
                    state_next       = RESP;
                end else begin
                    cnt_next = cnt_inc;
                    if (TIMEOUT_EN && (cnt_inc == CNT_LIMIT)) begin
                        psel_next        = 1'b0;
                        penable_next     = 1'b0;
                        rsp_valid_next   = 1'b1;
                        rsp_rdata_next   = 32'h0;
                        rsp_err_next     = 1'b1;
                        rsp_timeout_next = 1'b1;
                        state_next       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state_reg == IDLE) && !rst;
    assign busy         = (state_reg != IDLE);
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = rsp_rdata_reg;
    assign rsp_err      = rsp_err_reg;
    assign rsp_timeout  = rsp_timeout_reg;
    assign apbm_psel    = psel_reg;
    assign apbm_penable = penable_reg;
    assign apbm_pwrite  = pwrite_reg;
    assign apbm_paddr   = paddr_reg;
    assign apbm_pwdata  = pwdata_reg;

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: directed commands, an APB slave model with
// configurable wait states, and a monitor that checks every response and its latency.
module tb_apb_initiator;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic        apbm_psel;
    logic        apbm_penable;
    logic        apbm_pwrite;
    logic [15:0] apbm_paddr;
    logic [31:0] apbm_pwdata;
    logic [31:0] apbm_prdata = '0;
    logic        apbm_pready = 1'b0;
    logic        apbm_pslverr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t exp_q[$];
    cfg_t cfg_q[$];

    apb_initiator #(
        .ADDR_W (16),
        .TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .apbm_psel   (apbm_psel),
        .apbm_penable(apbm_penable),
        .apbm_pwrite (apbm_pwrite),
        .apbm_paddr  (apbm_paddr),
        .apbm_pwdata (apbm_pwdata),
        .apbm_prdata (apbm_prdata),
        .apbm_pready (apbm_pready),
        .apbm_pslverr(apbm_pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Slave model plus response monitor, both sampling on the falling edge.
    int          cyc = 0;
    int          acc_in_xfer = 0;
    int          access_total = 0;
    int          setup_total = 0;
    int          acc_prev = 0;
    int          setup_prev = 0;
    int          accept_q[$];
    int          rsp_count = 0;
    bit          seen = 0;
    bit          have_exp = 0;
    exp_t        cur_exp;
    cfg_t        cur_cfg;
    logic [31:0] snap_rdata;
    logic        snap_err;
    logic        snap_to;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            accept_q.delete();
            seen        = 0;
            acc_prev    = access_total;
            setup_prev  = setup_total;
            apbm_pready = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) accept_q.push_back(cyc);
            if (rsp_valid) begin
                check("cmd_ready_while_rsp", {31'b0, cmd_ready}, 32'd0);
                if (!seen) begin
                    seen       = 1;
                    snap_rdata = rsp_rdata;
                    snap_err   = rsp_err;
                    snap_to    = rsp_timeout;
                    check("rsp_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    have_exp = (exp_q.size() != 0);
                    if (have_exp) begin
                        cur_exp = exp_q.pop_front();
                        if (accept_q.size() != 0) check("latency", 32'(cyc - accept_q.pop_front()), 32'(cur_exp.lat));
                    end
                end else begin
                    check("rdata_stable", rsp_rdata, snap_rdata);
                    check("err_stable", {31'b0, rsp_err}, {31'b0, snap_err});
                    check("timeout_stable", {31'b0, rsp_timeout}, {31'b0, snap_to});
                end
                if (rsp_ready) begin
                    if (have_exp) begin
                        check("rsp_rdata", rsp_rdata, cur_exp.rdata);
                        check("rsp_err", {31'b0, rsp_err}, {31'b0, cur_exp.err});
                        check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, cur_exp.to});
                        check("access_cycles", 32'(access_total - acc_prev), 32'(cur_exp.acc));
                        check("setup_cycles", 32'(setup_total - setup_prev), 32'd1);
                    end
                    $display("rsp %0d: rdata=0x%08h err=%0b timeout=%0b access_cycles=%0d",
                             rsp_count, rsp_rdata, rsp_err, rsp_timeout, access_total - acc_prev);
                    rsp_count++;
                    acc_prev   = access_total;
                    setup_prev = setup_total;
                    seen       = 0;
                end
            end

            if (apbm_psel && !apbm_penable) begin
                setup_total++;
                acc_in_xfer = 0;
                check("setup_has_cfg", {31'b0, cfg_q.size() != 0}, 32'd1);
                if (cfg_q.size() != 0) cur_cfg = cfg_q.pop_front();
                apbm_pready = 1'b0;
            end else if (apbm_psel && apbm_penable) begin
                acc_in_xfer++;
                access_total++;
                check("paddr", {16'b0, apbm_paddr}, {16'b0, cur_cfg.addr});
                check("pwrite", {31'b0, apbm_pwrite}, {31'b0, cur_cfg.write});
                if (cur_cfg.write) check("pwdata", apbm_pwdata, cur_cfg.wdata);
                if (acc_in_xfer > cur_cfg.waits) begin
                    apbm_pready  = 1'b1;
                    apbm_prdata  = cur_cfg.prdata;
                    apbm_pslverr = cur_cfg.slverr;
                end else begin
                    // Junk on prdata/pslverr while not ready: must be ignored by the DUT.
                    apbm_pready  = 1'b0;
                    apbm_prdata  = 32'hDEAD_BEEF;
                    apbm_pslverr = 1'b1;
                end
            end else begin
                apbm_pready  = 1'b0;
                apbm_prdata  = 32'hDEAD_BEEF;
                apbm_pslverr = 1'b0;
            end
        end
    end

    task automatic add_cfg(input logic w, input logic [15:0] a, input logic [31:0] d,
                           input int waits, input logic [31:0] prd, input logic serr);
        cfg_t c;
        c.write = w; c.addr = a; c.wdata = d; c.waits = waits; c.prdata = prd; c.slverr = serr;
        cfg_q.push_back(c);
    endtask

    task automatic add_exp(input logic [31:0] rd, input logic er, input logic to, input int acc, input int lat);
        exp_t e;
        e.rdata = rd; e.err = er; e.to = to; e.acc = acc; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_cmd_ready();
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_seen", {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        wait_cmd_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int hold);
        int n = 0;
        rsp_ready = 1'b0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_psel", {31'b0, apbm_psel}, 32'd0);
        check("rst_penable", {31'b0, apbm_penable}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_paddr", {16'b0, apbm_paddr}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;

        // Read, zero wait states.
        add_cfg(1'b0, 16'h0008, 32'h0, 0, 32'h0000_00A5, 1'b0);
        add_exp(32'h0000_00A5, 1'b0, 1'b0, 1, 3);
        send(1'b0, 16'h0008, 32'h0);
        wait_rsp(0);

        // Write, 3 wait states: read data must come back as zero.
        add_cfg(1'b1, 16'h0010, 32'h0000_003C, 3, 32'h1234_5678, 1'b0);
        add_exp(32'h0, 1'b0, 1'b0, 4, 6);
        send(1'b1, 16'h0010, 32'h0000_003C);
        wait_rsp(0);

        // Read with slave error, held for two cycles of backpressure.
        add_cfg(1'b0, 16'h0020, 32'h0, 1, 32'hBAD0_0001, 1'b1);
        add_exp(32'hBAD0_0001, 1'b1, 1'b0, 2, 4);
        send(1'b0, 16'h0020, 32'h0);
        wait_rsp(2);

        // Write with slave error at the top of the address range.
        add_cfg(1'b1, 16'hFFFC, 32'hFFFF_FFFF, 0, 32'hAAAA_AAAA, 1'b1);
        add_exp(32'h0, 1'b1, 1'b0, 1, 3);
        send(1'b1, 16'hFFFC, 32'hFFFF_FFFF);
        wait_rsp(0);

        // Timeout: slave never ready, abort after 4 ACCESS cycles.
        add_cfg(1'b0, 16'h0030, 32'h0, 100, 32'h0000_0077, 1'b0);
        add_exp(32'h0, 1'b1, 1'b1, 4, 6);
        send(1'b0, 16'h0030, 32'h0);
        wait_rsp(0);

        // Boundary: pready arrives on the 4th ACCESS cycle, completion wins.
        add_cfg(1'b0, 16'h0034, 32'h0, 3, 32'hC0DE_0004, 1'b0);
        add_exp(32'hC0DE_0004, 1'b0, 1'b0, 4, 6);
        send(1'b0, 16'h0034, 32'h0);
        wait_rsp(0);

        // Backpressure with a second command held on the port.
        add_cfg(1'b0, 16'h0040, 32'h0, 0, 32'h1111_0040, 1'b0);
        add_exp(32'h1111_0040, 1'b0, 1'b0, 1, 3);
        add_cfg(1'b1, 16'h0044, 32'hCAFE_F00D, 1, 32'h0000_0099, 1'b0);
        add_exp(32'h0, 1'b0, 1'b0, 2, 4);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0040;
        cmd_wdata = 32'h0;
        wait_cmd_ready();
        @(posedge clk); #1;
        cmd_write = 1'b1;
        cmd_addr  = 16'h0044;
        cmd_wdata = 32'hCAFE_F00D;
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        repeat (5) begin
            check("bp_cmd_stalled", {31'b0, cmd_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_ready_after_hs", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_second_accepted", {31'b0, busy}, 32'd1);
        cmd_valid = 1'b0;
        wait_rsp(0);

        // Asynchronous reset during a wait state: transfer discarded, no response.
        add_cfg(1'b0, 16'h0050, 32'h0, 100, 32'h0000_0005, 1'b0);
        send(1'b0, 16'h0050, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_psel_before_rst", {31'b0, apbm_psel}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_psel", {31'b0, apbm_psel}, 32'd0);
        check("mid_rst_penable", {31'b0, apbm_penable}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            check("no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
        end
        check("cmd_ready_after_mid_rst", {31'b0, cmd_ready}, 32'd1);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("cfg_q_drained", 32'(cfg_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
